// File: rtl/coin_event_capture_if.sv
// Bundle between one coin beam sensor capture block and its CPU wrapper.
// The slave modport is the capture side; the master modport is the wrapper side.
interface coin_event_capture_if #(
    parameter int COUNT_W = 8
);
    logic               reading;
    logic               ack;
    logic               beamBroken;
    logic               coinEvent;
    logic [COUNT_W-1:0] coinCount;
    logic               coinPending;
    logic               overflow;
    logic [31:0]        mmioData;

    modport master (
        output reading,
        output ack,
        input  beamBroken,
        input  coinEvent,
        input  coinCount,
        input  coinPending,
        input  overflow,
        input  mmioData
    );

    modport slave (
        input  reading,
        input  ack,
        output beamBroken,
        output coinEvent,
        output coinCount,
        output coinPending,
        output overflow,
        output mmioData
    );
endinterface

// File: rtl/coin_event_capture.sv
// Coin beam-break capture: sync, debounce, one event per break,
// saturating coin count with sticky overflow and an MMIO read word.
module coin_event_capture #(
    parameter int   DEBOUNCE_CYCLES = 30000,
    parameter int   COUNT_W         = 8,
    parameter logic BROKEN_LEVEL    = 1'b0
) (
    input logic                  clock,
    input logic                  reset,
    coin_event_capture_if.slave  bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic               sync1;
    logic               sync2;
    logic               brk_s;
    logic [DB_W-1:0]    db_cnt;
    logic               brk;
    logic               db_done;
    logic               evt;
    logic               evt_q;
    logic [COUNT_W-1:0] count;
    logic               ovf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= ~BROKEN_LEVEL;
            sync2 <= ~BROKEN_LEVEL;
        end else begin
            sync1 <= bus.reading;
            sync2 <= sync1;
        end
    end

    assign brk_s   = (sync2 == BROKEN_LEVEL);
    assign db_done = (brk_s != brk) && (db_cnt == DB_MAX);
    // Only the clear-to-broken transition counts as a coin
    assign evt     = db_done && !brk;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt <= '0;
            brk    <= 1'b0;
        end else if (brk_s == brk) begin
            db_cnt <= '0;
        end else if (db_done) begin
            db_cnt <= '0;
            brk    <= ~brk;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            evt_q <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            evt_q <= evt;
            // A coin landing on the ack edge survives the clear
            if (bus.ack) begin
                count <= evt ? COUNT_W'(1) : '0;
                ovf   <= 1'b0;
            end else if (evt) begin
                if (count == CNT_MAX) ovf <= 1'b1;
                else count <= count + 1'b1;
            end
        end
    end

    assign bus.beamBroken  = brk;
    assign bus.coinEvent   = evt_q;
    assign bus.coinCount   = count;
    assign bus.coinPending = (count != '0);
    assign bus.overflow    = ovf;
    assign bus.mmioData    = {ovf, 14'b0, bus.coinPending,
                              {(16-COUNT_W){1'b0}}, count};
endmodule

// File: tb/tb_coin_event_capture.sv
// Directed bench for coin_event_capture with a short debounce window.
// Table rows hold steady inputs and expected state; corner cases are hand sequences.
module tb_coin_event_capture;
    localparam int D = 16;

    typedef struct {
        logic       rd;
        int         cyc;
        logic       ack;
        logic       brk;
        logic [7:0] cnt;
        logic       ovf;
        int         ev;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ev_total = 0;
    int   brk_hi = 0;

    coin_event_capture_if #(.COUNT_W(8)) bus ();

    coin_event_capture #(
        .DEBOUNCE_CYCLES(D),
        .COUNT_W(8),
        .BROKEN_LEVEL(1'b0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.coinEvent === 1'b1) ev_total++;
        if (bus.beamBroken === 1'b1) brk_hi++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mmio(input logic o, input logic [7:0] c);
        return {o, 14'b0, (c != 8'd0), 8'b0, c};
    endfunction

    task automatic check_state(input string tag, input logic b,
                               input logic [7:0] c, input logic o);
        check({tag, ".brk"}, 32'(bus.beamBroken), 32'(b));
        check({tag, ".cnt"}, 32'(bus.coinCount), 32'(c));
        check({tag, ".ovf"}, 32'(bus.overflow), 32'(o));
        check({tag, ".pend"}, 32'(bus.coinPending), 32'(c != 8'd0));
        check({tag, ".mmio"}, bus.mmioData, mmio(o, c));
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
    endtask

    task automatic do_break();
        bus.reading = 1'b0;
        step(D + 4);
        bus.reading = 1'b1;
        step(D + 4);
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        int base;
        int hi0;

        bus.reading = 1'b1;
        bus.ack = 1'b0;
        step(3);
        check_state("reset", 1'b0, 8'd0, 1'b0);
        check("reset.evt", 32'(bus.coinEvent), 32'd0);
        reset = 1'b0;

        // Idle beam produces nothing
        step(200);
        check_state("idle", 1'b0, 8'd0, 1'b0);
        check("idle.mmio0", bus.mmioData, 32'h0000_0000);
        check("idle.events", 32'(ev_total), 32'd0);

        // First break: latency from pin edge to beamBroken
        bus.reading = 1'b0;
        lat = -1;
        for (int i = 1; i <= D + 10; i++) begin
            step(1);
            if (lat < 0 && bus.beamBroken) lat = i;
        end
        n_cmp++;
        if (lat < D + 1 || lat > D + 3) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles expected %0d +/-1", lat, D + 2);
        end
        check_state("first", 1'b1, 8'd1, 1'b0);
        check("first.mmio", bus.mmioData, 32'h0001_0001);
        check("first.events", 32'(ev_total), 32'd1);

        vecs[0] = '{1'b1, D + 10, 1'b0, 1'b0, 8'd1, 1'b0, 0};
        vecs[1] = '{1'b1, 2,      1'b1, 1'b0, 8'd0, 1'b0, 0};
        vecs[2] = '{1'b1, 2,      1'b1, 1'b0, 8'd0, 1'b0, 0};
        vecs[3] = '{1'b0, D + 4,  1'b0, 1'b1, 8'd1, 1'b0, 1};
        vecs[4] = '{1'b1, D + 4,  1'b0, 1'b0, 8'd1, 1'b0, 1};
        vecs[5] = '{1'b0, D + 4,  1'b0, 1'b1, 8'd2, 1'b0, 2};
        vecs[6] = '{1'b1, D + 4,  1'b0, 1'b0, 8'd2, 1'b0, 2};
        vecs[7] = '{1'b0, D + 4,  1'b0, 1'b1, 8'd3, 1'b0, 3};
        vecs[8] = '{1'b1, D + 4,  1'b0, 1'b0, 8'd3, 1'b0, 3};
        vecs[9] = '{1'b1, 2,      1'b1, 1'b0, 8'd0, 1'b0, 3};

        base = ev_total;
        for (int v = 0; v < 10; v++) begin
            bus.reading = vecs[v].rd;
            step(vecs[v].cyc);
            if (vecs[v].ack) pulse_ack();
            check_state($sformatf("vec%0d", v), vecs[v].brk,
                        vecs[v].cnt, vecs[v].ovf);
            check($sformatf("vec%0d.events", v),
                  32'(ev_total - base), 32'(vecs[v].ev));
        end
        check("three.mmio_after_ack", bus.mmioData, 32'h0000_0000);

        // Short glitches never reach beamBroken
        base = ev_total;
        hi0 = brk_hi;
        for (int g = 0; g < 20; g++) begin
            bus.reading = 1'b0;
            step(D - 5);
            bus.reading = 1'b1;
            step(D - 5);
        end
        step(4);
        check_state("glitch", 1'b0, 8'd0, 1'b0);
        check("glitch.events", 32'(ev_total - base), 32'd0);
        check("glitch.brk_seen", 32'(brk_hi - hi0), 32'd0);

        // Saturation and sticky overflow
        base = ev_total;
        for (int k = 0; k < 256; k++) do_break();
        check_state("sat", 1'b0, 8'd255, 1'b1);
        check("sat.mmio", bus.mmioData, 32'h8001_00FF);
        check("sat.events", 32'(ev_total - base), 32'd256);
        pulse_ack();
        check_state("sat.ack", 1'b0, 8'd0, 1'b0);

        // Ack on the same edge as an event keeps the new coin
        for (int k = 0; k < 5; k++) do_break();
        check("pre.cnt", 32'(bus.coinCount), 32'd5);
        bus.reading = 1'b0;
        step(D + 1);
        check("pre.evt", 32'(bus.coinEvent), 32'd0);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        check("same.evt", 32'(bus.coinEvent), 32'd1);
        check_state("same", 1'b1, 8'd1, 1'b0);
        step(1);
        check("same.evt_len", 32'(bus.coinEvent), 32'd0);
        bus.reading = 1'b1;
        step(D + 4);
        check("same.hold", 32'(bus.coinCount), 32'd1);

        // Reset mid-debounce, beam held broken through release
        bus.reading = 1'b0;
        step(D / 2);
        #2 reset = 1'b1;
        #1;
        check_state("mid_rst", 1'b0, 8'd0, 1'b0);
        step(3);
        base = ev_total;
        reset = 1'b0;
        step(D + 4);
        check_state("post_rst", 1'b1, 8'd1, 1'b0);
        check("post_rst.events", 32'(ev_total - base), 32'd1);
        step(D + 4);
        check("post_rst.once", 32'(ev_total - base), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
